// File: rtl/wb_port_arb.sv
// rtl/wb_port_arb.sv - register-file write port arbiter between pipeline writeback and queued MDU results
module wb_port_arb #(
  parameter int DEPTH      = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_vld,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mdu_vld,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_rdy,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        stall_req,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  output logic        pend_hit
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [3:0]    LIM_C   = 4'(STARVE_LIM);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    starve_q, starve_d;
  logic [4:0]    rd_mem_q   [DEPTH];
  logic [4:0]    rd_mem_d   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   data_mem_d [DEPTH];

  logic non_empty;
  logic full;
  logic pipe_live;
  logic fifo_win;
  logic pipe_win;
  logic enq;
  logic deq;

  // Arbitration: the FIFO head wins when the pipeline has had its fill of
  // consecutive wins, or when the pipeline has nothing live to write.
  always_comb begin
    non_empty = (count_q != '0);
    full      = (count_q == DEPTH_C);
    pipe_live = pipe_vld && (pipe_rd != 5'd0);
    fifo_win  = non_empty && ((starve_q == LIM_C) || !pipe_live);
    pipe_win  = pipe_live && !fifo_win;
    enq       = mdu_vld && !full && (mdu_rd != 5'd0);
    deq       = fifo_win;
  end

  // Outputs; reset forces them quiet even while pipe_vld is still driven.
  always_comb begin
    mdu_rdy   = !full;
    rf_we     = 1'b0;
    rf_rd     = 5'd0;
    rf_data   = 32'd0;
    stall_req = 1'b0;
    if (!rst) begin
      if (fifo_win) begin
        rf_we     = 1'b1;
        rf_rd     = rd_mem_q[head_q];
        rf_data   = data_mem_q[head_q];
        stall_req = pipe_live;
      end else if (pipe_win) begin
        rf_we   = 1'b1;
        rf_rd   = pipe_rd;
        rf_data = pipe_data;
      end
    end
  end

  // Pending-result scoreboard: an entry is occupied when its distance from
  // the head is below the occupancy; stale slots never match.
  always_comb begin
    logic [PW-1:0] offs;
    pend_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - head_q;
      if (({1'b0, offs} < count_q) &&
          (((chk_rs1 != 5'd0) && (rd_mem_q[i] == chk_rs1)) ||
           ((chk_rs2 != 5'd0) && (rd_mem_q[i] == chk_rs2)))) begin
        pend_hit = 1'b1;
      end
    end
    if (rst) begin
      pend_hit = 1'b0;
    end
  end

  // Next-state for FIFO pointers, occupancy, storage and starvation counter.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    starve_d   = starve_q;
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (enq) begin
      rd_mem_d[tail_q]   = mdu_rd;
      data_mem_d[tail_q] = mdu_data;
      tail_d             = tail_q + PTR_ONE;
    end
    if (deq) begin
      head_d = head_q + PTR_ONE;
    end
    if (enq && !deq) begin
      count_d = count_q + CNT_ONE;
    end else if (deq && !enq) begin
      count_d = count_q - CNT_ONE;
    end
    if (deq) begin
      starve_d = 4'd0;
    end else if (pipe_win && non_empty && (starve_q != LIM_C)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // State registers with asynchronous reset that drops every queued result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= 5'd0;
        data_mem_q[i] <= 32'd0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

endmodule
